dot_mac_seq: RTL



---
 rtl/dot_mac_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dot_mac_seq.sv
// dot_mac_seq: operand-select sequencer and signed multiply-accumulate for one result element.
// Build option MAC_SAT_EN: clamp the narrowed result to the DATA_W range and flag sat instead of wrapping.
module dot_mac_seq #(
    parameter int DATA_W = 16,
    parameter int LEN    = 32,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2*DATA_W+5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [4:0]        a_sel,
    output logic [4:0]        b_sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    localparam int         PROD_W = 2*DATA_W;
    localparam logic [4:0] LAST   = 5'(LEN-1);
`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] P_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] P_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Returns {sat, result}: arithmetic shift by FRAC, then narrow to DATA_W.
    function automatic logic [DATA_W:0] narrow(input logic signed [ACC_W-1:0] acc);
`ifdef MAC_SAT_EN
        if ((acc >>> FRAC) > P_MAX) begin
            narrow = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end else if ((acc >>> FRAC) < P_MIN) begin
            narrow = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            narrow = {1'b0, DATA_W'(acc >>> FRAC)};
        end
`else
        narrow = {1'b0, DATA_W'(acc >>> FRAC)};
`endif
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [4:0]                r_cnt;
    logic signed [PROD_W-1:0]  r_prod_p1;
    logic                      r_vld_p1;
    logic signed [ACC_W-1:0]   r_acc_p2;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]         r_result_p3;
    logic                      r_sat_p3;
    logic                      r_valid_p3;
    logic [DATA_W:0]           w_narrow;
    logic                      w_take;

    assign w_take    = r_valid_p3 && out_ready;
    assign w_acc_nxt = r_vld_p1 ? (r_acc_p2 + $signed({{(ACC_W-PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1}))
                                : r_acc_p2;
    assign w_narrow  = narrow(w_acc_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (w_take) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p1: product of the currently selected operand pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_prod_p1 <= $signed(a_data) * $signed(b_data);
            end
        end
    end

    // p2: select counter and accumulator; the last product lands on the DRAIN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc_p2 <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_acc_p2 <= '0;
                    end
                end
                S_RUN: begin
                    r_acc_p2 <= w_acc_nxt;
                    if (r_cnt != LAST) r_cnt <= r_cnt + 5'd1;
                end
                S_DRAIN: r_acc_p2 <= w_acc_nxt;
                default: ;
            endcase
        end
    end

    // p3: narrowed result held for the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_p3 <= '0;
            r_sat_p3    <= 1'b0;
            r_valid_p3  <= 1'b0;
        end else begin
            if (r_state == S_DRAIN) begin
                r_result_p3 <= w_narrow[DATA_W-1:0];
                r_sat_p3    <= w_narrow[DATA_W];
                r_valid_p3  <= 1'b1;
            end else if (r_state == S_DONE && w_take) begin
                r_valid_p3 <= 1'b0;
            end
        end
    end

    assign a_sel     = r_cnt;
    assign b_sel     = r_cnt;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_valid_p3;
    assign result    = r_result_p3;
    assign sat       = r_sat_p3;

endmodule
